// File: rtl/stage3_fetch_unit.sv
// Fetch stage: PC register, instruction-bus request handshake and IF/EX latch.
// Redirects landing on an in-flight bus transaction are absorbed by draining it.
module stage3_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_en,
    input  logic        npc_sel,
    input  logic [31:0] brj_addr,
    input  logic        insert_priv_pc,
    input  logic [31:0] priv_pc,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        iren,
    input  logic        suppress_iren,
    input  logic        if_ex_stall,
    input  logic        if_ex_flush,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busy,
    output logic        i_mem_busy,
    output logic [31:0] pc_f,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc4,
    output logic        fetch_mal
);

    typedef enum logic {FETCH, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] lpc_q, lpc_d;
    logic        mal_q, mal_d;

    logic        aligned, fetch_req, fetch_done, redirect;
    logic [31:0] npc;

    always_comb begin
        aligned    = (pc_q[1:0] == 2'b00);
        fetch_req  = iren & ~suppress_iren;
        imem_addr  = pc_q;
        imem_ren   = 1'b0;
        fetch_done = 1'b0;
        if (state_q == DRAIN) begin
            // The bus transaction is never aborted, so keep presenting it.
            imem_addr = drain_addr_q;
            imem_ren  = ~RST;
        end else begin
            imem_ren   = fetch_req & aligned & ~RST;
            fetch_done = (imem_ren & ~imem_busy) | (fetch_req & ~aligned);
        end
        i_mem_busy = ~fetch_done;
        pc_f       = pc_q;

        redirect = pc_en & (insert_priv_pc | rollback | npc_sel);
        if (insert_priv_pc)  npc = priv_pc;
        else if (rollback)   npc = rollback_pc;
        else if (npc_sel)    npc = brj_addr;
        else                 npc = pc_q + 32'd4;
        pc_d = pc_en ? npc : pc_q;

        state_d      = state_q;
        drain_addr_d = drain_addr_q;
        if (state_q == FETCH) begin
            if (redirect & imem_ren & imem_busy) begin
                state_d      = DRAIN;
                drain_addr_d = pc_q;
            end
        end else if (!imem_busy) begin
            state_d = FETCH;
        end

        valid_d = valid_q;
        instr_d = instr_q;
        lpc_d   = lpc_q;
        mal_d   = mal_q;
        if (if_ex_flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSN;
            lpc_d   = 32'd0;
            mal_d   = 1'b0;
        end else if (!if_ex_stall) begin
            if (fetch_done) begin
                valid_d = 1'b1;
                lpc_d   = pc_q;
                mal_d   = ~aligned;
                instr_d = aligned ? imem_rdata : NOP_INSN;
            end else begin
                // Bubble keeps the last PC; only valid/instr/mal are cleared.
                valid_d = 1'b0;
                instr_d = NOP_INSN;
                mal_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'd0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSN;
            lpc_q        <= 32'd0;
            mal_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            lpc_q        <= lpc_d;
            mal_q        <= mal_d;
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_instr = instr_q;
    assign fetch_pc    = lpc_q;
    assign fetch_pc4   = lpc_q + 32'd4;
    assign fetch_mal   = mal_q;

endmodule
